// File: rtl/times_table_writer_if.sv
// Times-table RAM write bus: control handshake (start/stall/busy/done) plus the RAM write port.
// Latency: none, a plain signal bundle.
// Backpressure: stall is driven by the control/memory side and must be honoured by the writer.
//
// Modports:
//   master - control/memory side: drives start, stall; observes the write port and status.
//   slave  - the table writer: samples start, stall; drives ena, wea, addra, dina, busy, done.
interface times_table_writer_if #(
    parameter int OP_BITS   = 3,
    parameter int ADDR_BITS = 2 * OP_BITS,
    parameter int DATA_BITS = 2 * OP_BITS
) ();
    logic                 start;
    logic                 stall;
    logic                 ena;
    logic                 wea;
    logic [ADDR_BITS-1:0] addra;
    logic [DATA_BITS-1:0] dina;
    logic                 busy;
    logic                 done;

    modport master (
        output start,
        output stall,
        input  ena,
        input  wea,
        input  addra,
        input  dina,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  stall,
        output ena,
        output wea,
        output addra,
        output dina,
        output busy,
        output done
    );
endinterface

// File: rtl/times_table_writer.sv
// Builds the a*b times table in a single-port RAM at run time, address {a,b}, using repeated addition.
// Latency: start at edge k -> writes on cycles k+1..k+N*N, done pulse on cycle k+N*N+1.
// Backpressure: stall=1 freezes the sweep (no write, busy held) and it resumes at the same entry.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of times_table_writer_if (start/stall in; ena/wea/addra/dina/busy/done out)
module times_table_writer #(
    parameter int OP_BITS   = 3,
    parameter int ADDR_BITS = 2 * OP_BITS,
    parameter int DATA_BITS = 2 * OP_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    times_table_writer_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [OP_BITS-1:0] OP_MAX = {OP_BITS{1'b1}};

    logic [1:0]           state_q, state_d;
    logic [OP_BITS-1:0]   a_q, a_d;
    logic [OP_BITS-1:0]   b_q, b_d;
    logic [DATA_BITS-1:0] acc_q, acc_d;
    logic                 ena_q, ena_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [ADDR_BITS-1:0] addra_q, addra_d;
    logic [DATA_BITS-1:0] dina_q, dina_d;

    // Outputs are registered one step behind the state: the edge that sees
    // state WRITE with stall=0 launches the write of entry (a,b) for the
    // following cycle, and the edge that sees state DONE launches done.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        addra_d = addra_q;
        dina_d  = dina_q;
        ena_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_WRITE;
                    a_d     = '0;
                    b_d     = '0;
                    acc_d   = '0;
                end
            end

            ST_WRITE: begin
                busy_d = 1'b1;
                // A stalled cycle keeps a/b/acc and the last address/data.
                if (!bus.stall) begin
                    ena_d   = 1'b1;
                    addra_d = ADDR_BITS'({a_q, b_q});
                    dina_d  = acc_q;
                    if (b_q != OP_MAX) begin
                        // Next column of the same row: product grows by a.
                        b_d   = b_q + 1'b1;
                        acc_d = acc_q + DATA_BITS'(a_q);
                    end else if (a_q != OP_MAX) begin
                        // New row: column 0 always starts from a zero product.
                        a_d   = a_q + 1'b1;
                        b_d   = '0;
                        acc_d = '0;
                    end else begin
                        // Last entry is being written now.
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            ena_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            ena_q   <= ena_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
        end
    end

    // Every enabled cycle is a write, so ena and wea share one register.
    assign bus.ena   = ena_q;
    assign bus.wea   = ena_q;
    assign bus.addra = addra_q;
    assign bus.dina  = dina_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_times_table_writer.sv
module tb_times_table_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    times_table_writer_if #(.OP_BITS(3)) bus ();

    times_table_writer #(.OP_BITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model of the RAM contents as seen through the write port.
    logic [5:0] ram [64];

    typedef struct {
        string name;
        int    stall_pct;
        int    pre_stall;
        int    restart_at;
        int    exp_writes;
        int    exp_dones;
    } scen_t;

    typedef struct {
        int addr;
        int exp_val;
    } spot_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then drives stall per cycle and checks every output
    // against a model that only knows "how many writes have happened so far".
    task automatic run_sweep(input string name, input int stall_pct, input int pre_stall,
                             input int restart_at, output int writes, output int dones);
        int  stalls;
        int  last_w;
        int  done_j;
        logic s;
        logic exp_wr;
        logic exp_busy;
        logic exp_done;
        writes = 0;
        dones  = 0;
        stalls = 0;
        last_w = -10;
        done_j = -1;
        bus.stall = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 1; j <= 400; j++) begin
            s = (j <= pre_stall) || ($urandom_range(99) < stall_pct);
            bus.stall = s;
            bus.start = (restart_at >= 0) && (writes == restart_at);
            exp_wr   = (writes < 64) && !s;
            exp_busy = (writes < 64);
            exp_done = (writes == 64) && (j == last_w + 1);
            if (writes < 64 && s) stalls++;
            tick();
            check({name, ":wea"},  bus.wea,  exp_wr);
            check({name, ":ena"},  bus.ena,  exp_wr);
            check({name, ":busy"}, bus.busy, exp_busy);
            check({name, ":done"}, bus.done, exp_done);
            if (bus.wea) begin
                check({name, ":addr"}, bus.addra, writes);
                check({name, ":data"}, bus.dina, (writes >> 3) * (writes & 7));
                ram[bus.addra] = bus.dina;
                writes++;
                last_w = j;
            end
            if (bus.done) begin
                dones++;
                if (done_j < 0) done_j = j;
            end
            if (writes >= 64 && j > last_w + 3) break;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        check({name, ":done_latency"}, done_j, 64 + stalls + 1);
    endtask

    initial begin
        scen_t scens [5];
        spot_t spots [8];
        int    w;
        int    d;
        int    found;
        int    phase;
        logic  ew;

        scens[0] = '{"plain",        0,  0, -1, 64, 1};
        scens[1] = '{"stall_rand",  30,  0, -1, 64, 1};
        scens[2] = '{"stall_first", 20,  3, -1, 64, 1};
        scens[3] = '{"restart30",    0,  0, 30, 64, 1};
        scens[4] = '{"restart30_st",25,  0, 30, 64, 1};

        spots[0] = '{0, 0};
        spots[1] = '{19, 6};
        spots[2] = '{42, 10};
        spots[3] = '{63, 49};
        spots[4] = '{9, 1};
        spots[5] = '{56, 0};
        spots[6] = '{7, 0};
        spots[7] = '{62, 42};

        bus.start = 1'b0;
        bus.stall = 1'b0;

        // Reset state.
        #22;
        check("rst:ena",   bus.ena,   0);
        check("rst:wea",   bus.wea,   0);
        check("rst:busy",  bus.busy,  0);
        check("rst:done",  bus.done,  0);
        check("rst:addra", bus.addra, 0);
        check("rst:dina",  bus.dina,  0);
        tick();
        rst_n = 1'b1;
        tick();

        // Stall while idle has no effect.
        bus.stall = 1'b1;
        tick();
        tick();
        check("idle_stall:wea",  bus.wea,  0);
        check("idle_stall:busy", bus.busy, 0);
        bus.stall = 1'b0;

        foreach (scens[i]) begin
            run_sweep(scens[i].name, scens[i].stall_pct, scens[i].pre_stall,
                      scens[i].restart_at, w, d);
            check({scens[i].name, ":writes"}, w, scens[i].exp_writes);
            check({scens[i].name, ":dones"},  d, scens[i].exp_dones);
            if (i == 0) begin
                foreach (spots[k])
                    check($sformatf("spot%0d", spots[k].addr), ram[spots[k].addr], spots[k].exp_val);
            end
            tick();
        end

        // Full table read-back of the RAM model.
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                check($sformatf("table[%0d][%0d]", a, b), ram[a * 8 + b], a * b);

        // Asynchronous reset in the middle of a cycle during the sweep.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        found = 0;
        for (int j = 0; j < 100; j++) begin
            tick();
            if (bus.wea && bus.addra == 6'd20) begin
                found = 1;
                break;
            end
        end
        check("arst:reach_write20", found, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst:ena",   bus.ena,   0);
        check("arst:wea",   bus.wea,   0);
        check("arst:busy",  bus.busy,  0);
        check("arst:done",  bus.done,  0);
        check("arst:addra", bus.addra, 0);
        check("arst:dina",  bus.dina,  0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("arst:idle_after", bus.busy, 0);
        run_sweep("after_rst", 10, 0, -1, w, d);
        check("after_rst:writes", w, 64);
        check("after_rst:dones",  d, 1);
        tick();

        // start held high: back-to-back sweeps, 64 writes + DONE + IDLE each.
        w = 0;
        d = 0;
        bus.start = 1'b1;
        tick();
        for (int j = 1; j <= 200; j++) begin
            tick();
            phase = j % 66;
            ew = (phase >= 1) && (phase <= 64);
            check("held:wea",  bus.wea,  ew);
            check("held:done", bus.done, phase == 65);
            if (ew) check("held:addr", bus.addra, phase - 1);
            if (bus.wea) w++;
            if (bus.done) d++;
        end
        bus.start = 1'b0;
        found = 0;
        for (int j = 0; j < 100; j++) begin
            tick();
            if (bus.wea) w++;
            if (bus.done) begin
                d++;
                found = 1;
                break;
            end
        end
        check("held:final_done", found, 1);
        check("held:writes", w, 256);
        check("held:dones",  d, 4);
        tick();
        tick();
        check("held:idle_wea",  bus.wea,  0);
        check("held:idle_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
